writeback_store_buffer: RTL and testbench

- Parametrised successor to the single-entry writeback memory path.
- Accepts retired stores from the writeback stage into a DEPTH-entry FIFO, so writeback never stalls on a single outstanding write.
- Drains entries in order to the D-cache using the reqcyc/reqack/writeack handshake.
- Forwards the youngest buffered store data to load lookups, and reports per-store completion and call-store completion.

---
 rtl/writeback_store_buffer.sv | 221 ++++++++++++++++++++++
 tb/tb_writeback_store_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_store_buffer.sv
// writeback_store_buffer
//   DEPTH-entry in-order store FIFO between the writeback stage and the D-cache.
//   Retired stores are queued so writeback does not stall on one outstanding
//   write. The head entry is drained through the reqcyc/reqack/writeack
//   handshake. Load lookups are forwarded from the youngest matching entry.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   enq_*               store from writeback (enq_ready = !full)
//   mem_*               D-cache request payload and handshake
//   fwd_addr/hit/data   combinational store-to-load forwarding
//   count/empty/full    occupancy, derived from registered state only
//   write_done          one-cycle pulse after each completed store
//   call_done           same pulse, only for stores flagged enq_is_call
//   state_dbg           drain FSM state (0 idle, 1 req, 2 wait)
//
// Handshake: mem_reqcyc is a registered valid that stays high with a stable
// payload until mem_reqack is seen. The store completes (and pops) on the edge
// where mem_writeack is seen after, or together with, mem_reqack.
module writeback_store_buffer #(
    parameter int   DEPTH      = 4,
    parameter int   ADDR_W     = 64,
    parameter int   DATA_W     = 64,
    parameter int   OPC_W      = 8,
    parameter logic TAG_WRITE  = 1'b1,
    parameter logic TAG_MEMORY = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [ADDR_W-1:0]          enq_addr,
    input  logic [DATA_W-1:0]          enq_data,
    input  logic [OPC_W-1:0]           enq_opcode,
    input  logic                       enq_is_call,
    output logic                       mem_reqcyc,
    output logic [ADDR_W-1:0]          mem_req,
    output logic [DATA_W-1:0]          mem_reqdata,
    output logic [OPC_W+1:0]           mem_reqtag,
    input  logic                       mem_reqack,
    input  logic                       mem_writeack,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       write_done,
    output logic                       call_done,
    output logic [1:0]                 state_dbg
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DEPTH-1:0]    call_q, call_d;
    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [ADDR_W-1:0]   addr_d [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DATA_W-1:0]   data_d [DEPTH];
    logic [OPC_W-1:0]    opc_q  [DEPTH];
    logic [OPC_W-1:0]    opc_d  [DEPTH];
    logic                mem_reqcyc_q, mem_reqcyc_d;
    logic [ADDR_W-1:0]   mem_req_q, mem_req_d;
    logic [DATA_W-1:0]   mem_reqdata_q, mem_reqdata_d;
    logic [OPC_W+1:0]    mem_reqtag_q, mem_reqtag_d;
    logic                write_done_q, write_done_d;
    logic                call_done_q, call_done_d;
    logic                do_enq, do_pop;
    logic [PTR_W-1:0]    fwd_idx;

    // Acceptance uses the pre-edge full flag, so a pop never frees a slot
    // for an enqueue on the same edge.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign enq_ready = !full;
    assign do_enq    = enq_valid && !full;

    // Drain FSM and request payload.
    always_comb begin
        state_d       = state_q;
        mem_reqcyc_d  = mem_reqcyc_q;
        mem_req_d     = mem_req_q;
        mem_reqdata_d = mem_reqdata_q;
        mem_reqtag_d  = mem_reqtag_q;
        write_done_d  = 1'b0;
        call_done_d   = 1'b0;
        do_pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d       = ST_REQ;
                    mem_reqcyc_d  = 1'b1;
                    mem_req_d     = addr_q[head_q];
                    mem_reqdata_d = data_q[head_q];
                    mem_reqtag_d  = {TAG_WRITE, TAG_MEMORY, opc_q[head_q]};
                end
            end
            ST_REQ: begin
                if (mem_reqack) begin
                    mem_reqcyc_d = 1'b0;
                    if (mem_writeack) begin
                        do_pop  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_writeack) begin
                    do_pop  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                mem_reqcyc_d = 1'b0;
            end
        endcase
        if (do_pop) begin
            write_done_d = 1'b1;
            call_done_d  = call_q[head_q];
        end
    end

    // Entry storage and pointers.
    always_comb begin
        valid_d = valid_q;
        call_d  = call_q;
        addr_d  = addr_q;
        data_d  = data_q;
        opc_d   = opc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (do_enq) begin
            valid_d[tail_q] = 1'b1;
            call_d[tail_q]  = enq_is_call;
            addr_d[tail_q]  = enq_addr;
            data_d[tail_q]  = enq_data;
            opc_d[tail_q]   = enq_opcode;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({do_enq, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk from oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            valid_q       <= '0;
            call_q        <= '0;
            mem_reqcyc_q  <= 1'b0;
            mem_req_q     <= '0;
            mem_reqdata_q <= '0;
            mem_reqtag_q  <= '0;
            write_done_q  <= 1'b0;
            call_done_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                opc_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            valid_q       <= valid_d;
            call_q        <= call_d;
            mem_reqcyc_q  <= mem_reqcyc_d;
            mem_req_q     <= mem_req_d;
            mem_reqdata_q <= mem_reqdata_d;
            mem_reqtag_q  <= mem_reqtag_d;
            write_done_q  <= write_done_d;
            call_done_q   <= call_done_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            opc_q         <= opc_d;
        end
    end

    assign mem_reqcyc  = mem_reqcyc_q;
    assign mem_req     = mem_req_q;
    assign mem_reqdata = mem_reqdata_q;
    assign mem_reqtag  = mem_reqtag_q;
    assign write_done  = write_done_q;
    assign call_done   = call_done_q;
    assign count       = count_q;
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_writeback_store_buffer.sv
module tb_writeback_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        enq_valid, enq_ready;
    logic [63:0] enq_addr, enq_data;
    logic [7:0]  enq_opcode;
    logic        enq_is_call;
    logic        mem_reqcyc;
    logic [63:0] mem_req, mem_reqdata;
    logic [9:0]  mem_reqtag;
    logic        mem_reqack, mem_writeack;
    logic [63:0] fwd_addr;
    logic        fwd_hit;
    logic [63:0] fwd_data;
    logic [2:0]  count;
    logic        empty, full, write_done, call_done;
    logic [1:0]  state_dbg;

    writeback_store_buffer dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
        .enq_data(enq_data), .enq_opcode(enq_opcode), .enq_is_call(enq_is_call),
        .mem_reqcyc(mem_reqcyc), .mem_req(mem_req), .mem_reqdata(mem_reqdata),
        .mem_reqtag(mem_reqtag), .mem_reqack(mem_reqack), .mem_writeack(mem_writeack),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count), .empty(empty), .full(full),
        .write_done(write_done), .call_done(call_done), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid = 0; enq_addr = '0; enq_data = '0; enq_opcode = '0;
        enq_is_call = 0; mem_reqack = 0; mem_writeack = 0; fwd_addr = '0;
    endtask

    task automatic enq(input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] o, input logic c);
        enq_valid = 1; enq_addr = a; enq_data = d; enq_opcode = o; enq_is_call = c;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        ev;
        logic [63:0] ea, ed;
        logic [7:0]  eo;
        logic        ra, wa;
        logic [63:0] fa;
        logic        x_cyc;
        logic [63:0] x_req, x_rdata;
        logic [9:0]  x_tag;
        logic [2:0]  x_cnt;
        logic        x_wd, x_cd, x_hit;
        logic [63:0] x_fd;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    function automatic vec_t mk(logic ev, logic [63:0] ea, logic [63:0] ed, logic [7:0] eo,
                                logic ra, logic wa, logic [63:0] fa,
                                logic x_cyc, logic [63:0] x_req, logic [63:0] x_rdata,
                                logic [9:0] x_tag, logic [2:0] x_cnt, logic x_wd,
                                logic x_cd, logic x_hit, logic [63:0] x_fd);
        vec_t v;
        v.ev = ev; v.ea = ea; v.ed = ed; v.eo = eo; v.ra = ra; v.wa = wa; v.fa = fa;
        v.x_cyc = x_cyc; v.x_req = x_req; v.x_rdata = x_rdata; v.x_tag = x_tag;
        v.x_cnt = x_cnt; v.x_wd = x_wd; v.x_cd = x_cd; v.x_hit = x_hit; v.x_fd = x_fd;
        return v;
    endfunction

    initial begin
        int wd_cnt;
        int n_req;
        logic prev_cyc;
        int budget;

        // Each row: inputs held across one rising edge, outputs checked after it.
        //             ev  addr     data     opc    ra wa fwd        cyc req      rdata    tag     cnt wd cd hit fdata
        vecs[0]  = mk(1, 'h1000, 'hDEAD, 'h89, 0, 0, 'h0,    0, 'h0,    'h0,    'h000, 1, 0, 0, 0, 'h0);
        vecs[1]  = mk(0, 'h0,    'h0,    'h0,  0, 0, 'h0,    1, 'h1000, 'hDEAD, 'h389, 1, 0, 0, 0, 'h0);
        vecs[2]  = mk(0, 'h0,    'h0,    'h0,  0, 0, 'h0,    1, 'h1000, 'hDEAD, 'h389, 1, 0, 0, 0, 'h0);
        vecs[3]  = mk(0, 'h0,    'h0,    'h0,  1, 0, 'h0,    0, 'h1000, 'hDEAD, 'h389, 1, 0, 0, 0, 'h0);
        vecs[4]  = mk(0, 'h0,    'h0,    'h0,  0, 0, 'h1000, 0, 'h1000, 'hDEAD, 'h389, 1, 0, 0, 1, 'hDEAD);
        vecs[5]  = mk(0, 'h0,    'h0,    'h0,  0, 0, 'h0,    0, 'h1000, 'hDEAD, 'h389, 1, 0, 0, 0, 'h0);
        vecs[6]  = mk(0, 'h0,    'h0,    'h0,  0, 1, 'h1000, 0, 'h1000, 'hDEAD, 'h389, 0, 1, 0, 0, 'h0);
        vecs[7]  = mk(0, 'h0,    'h0,    'h0,  0, 0, 'h0,    0, 'h1000, 'hDEAD, 'h389, 0, 0, 0, 0, 'h0);
        vecs[8]  = mk(1, 'h2000, 'h11,   'h01, 0, 0, 'h2000, 0, 'h1000, 'hDEAD, 'h389, 1, 0, 0, 1, 'h11);
        vecs[9]  = mk(1, 'h3000, 'h22,   'h02, 0, 0, 'h2000, 1, 'h2000, 'h11,   'h301, 2, 0, 0, 1, 'h11);
        vecs[10] = mk(1, 'h2000, 'h33,   'h03, 0, 0, 'h2000, 1, 'h2000, 'h11,   'h301, 3, 0, 0, 1, 'h33);
        vecs[11] = mk(0, 'h0,    'h0,    'h0,  0, 0, 'h4000, 1, 'h2000, 'h11,   'h301, 3, 0, 0, 0, 'h0);
        vecs[12] = mk(0, 'h0,    'h0,    'h0,  0, 0, 'h3000, 1, 'h2000, 'h11,   'h301, 3, 0, 0, 1, 'h22);
        vecs[13] = mk(0, 'h0,    'h0,    'h0,  1, 1, 'h2000, 0, 'h2000, 'h11,   'h301, 2, 1, 0, 1, 'h33);
        vecs[14] = mk(0, 'h0,    'h0,    'h0,  0, 0, 'h2000, 1, 'h3000, 'h22,   'h302, 2, 0, 0, 1, 'h33);
        vecs[15] = mk(0, 'h0,    'h0,    'h0,  1, 0, 'h2000, 0, 'h3000, 'h22,   'h302, 2, 0, 0, 1, 'h33);
        vecs[16] = mk(0, 'h0,    'h0,    'h0,  1, 0, 'h2000, 0, 'h3000, 'h22,   'h302, 2, 0, 0, 1, 'h33);
        vecs[17] = mk(0, 'h0,    'h0,    'h0,  0, 1, 'h2000, 0, 'h3000, 'h22,   'h302, 1, 1, 0, 1, 'h33);
        vecs[18] = mk(0, 'h0,    'h0,    'h0,  0, 0, 'h2000, 1, 'h2000, 'h33,   'h303, 1, 0, 0, 1, 'h33);
        vecs[19] = mk(0, 'h0,    'h0,    'h0,  0, 1, 'h2000, 1, 'h2000, 'h33,   'h303, 1, 0, 0, 1, 'h33);
        vecs[20] = mk(0, 'h0,    'h0,    'h0,  1, 1, 'h2000, 0, 'h2000, 'h33,   'h303, 0, 1, 0, 0, 'h0);
        vecs[21] = mk(0, 'h0,    'h0,    'h0,  0, 0, 'h2000, 0, 'h2000, 'h33,   'h303, 0, 0, 0, 0, 'h0);

        // ---------------- reset ----------------
        idle_inputs();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst reqcyc", 64'(mem_reqcyc), 64'd0);
        check("rst count", 64'(count), 64'd0);
        check("rst empty", 64'(empty), 64'd1);
        check("rst full", 64'(full), 64'd0);
        check("rst write_done", 64'(write_done), 64'd0);
        check("rst call_done", 64'(call_done), 64'd0);
        check("rst req", mem_req, 64'd0);
        check("rst reqtag", 64'(mem_reqtag), 64'd0);
        @(negedge clk);
        reset = 1;
        tick();

        // ---------------- table: single store, forwarding, handshake corners ----------------
        for (int i = 0; i < NV; i++) begin
            enq_valid = vecs[i].ev; enq_addr = vecs[i].ea; enq_data = vecs[i].ed;
            enq_opcode = vecs[i].eo; enq_is_call = 0;
            mem_reqack = vecs[i].ra; mem_writeack = vecs[i].wa; fwd_addr = vecs[i].fa;
            tick();
            check($sformatf("v%0d reqcyc", i), 64'(mem_reqcyc), 64'(vecs[i].x_cyc));
            check($sformatf("v%0d req", i), mem_req, vecs[i].x_req);
            check($sformatf("v%0d reqdata", i), mem_reqdata, vecs[i].x_rdata);
            check($sformatf("v%0d reqtag", i), 64'(mem_reqtag), 64'(vecs[i].x_tag));
            check($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].x_cnt));
            check($sformatf("v%0d empty", i), 64'(empty), 64'(vecs[i].x_cnt == 3'd0));
            check($sformatf("v%0d write_done", i), 64'(write_done), 64'(vecs[i].x_wd));
            check($sformatf("v%0d call_done", i), 64'(call_done), 64'(vecs[i].x_cd));
            check($sformatf("v%0d fwd_hit", i), 64'(fwd_hit), 64'(vecs[i].x_hit));
            check($sformatf("v%0d fwd_data", i), fwd_data, vecs[i].x_fd);
        end
        idle_inputs();

        // ---------------- call store, reqack+writeack together ----------------
        enq(64'h5000, 64'h77, 8'hE8, 1'b1);
        tick();
        idle_inputs();
        tick();
        check("call reqcyc", 64'(mem_reqcyc), 64'd1);
        check("call reqtag", 64'(mem_reqtag), 64'h3E8);
        mem_reqack = 1; mem_writeack = 1;
        tick();
        idle_inputs();
        check("call write_done", 64'(write_done), 64'd1);
        check("call call_done", 64'(call_done), 64'd1);
        check("call count", 64'(count), 64'd0);
        tick();
        check("call write_done end", 64'(write_done), 64'd0);
        check("call call_done end", 64'(call_done), 64'd0);

        // ---------------- fill with cache stalled, then drain in order ----------------
        for (int i = 0; i < 5; i++) begin
            enq(64'h100 * (i + 1), 64'hA0 + 64'(i), 8'h10, 1'b0);
            check($sformatf("fill%0d enq_ready", i), 64'(enq_ready), (i < 4) ? 64'd1 : 64'd0);
            if (i < 4) exp_q.push_back(64'h100 * (i + 1));
            tick();
        end
        idle_inputs();
        check("fill count", 64'(count), 64'd4);
        check("fill full", 64'(full), 64'd1);
        check("fill enq_ready", 64'(enq_ready), 64'd0);
        mem_reqack = 1; mem_writeack = 1;
        wd_cnt = 0; n_req = 0; prev_cyc = 1'b0; budget = 0;
        while (exp_q.size() > 0 && budget < 40) begin
            if (write_done) wd_cnt++;
            if (mem_reqcyc) begin
                check($sformatf("drain%0d addr", n_req), mem_req, exp_q.pop_front());
                if (n_req > 0) check($sformatf("drain%0d gap", n_req), 64'(prev_cyc), 64'd0);
                n_req++;
            end
            prev_cyc = mem_reqcyc;
            tick();
            budget++;
        end
        if (write_done) wd_cnt++;
        check("drain timeout", 64'(exp_q.size()), 64'd0);
        idle_inputs();
        check("drain write_done pulses", 64'(wd_cnt), 64'd4);
        check("drain count", 64'(count), 64'd0);
        tick();
        check("drain idle reqcyc", 64'(mem_reqcyc), 64'd0);

        // ---------------- reset in WAIT with 3 entries ----------------
        enq(64'hA00, 64'h1, 8'h20, 1'b0); tick();
        enq(64'hA10, 64'h2, 8'h20, 1'b0); tick();
        enq(64'hA20, 64'h3, 8'h20, 1'b0); tick();
        idle_inputs();
        mem_reqack = 1;
        tick();
        mem_reqack = 0;
        check("midrst count before", 64'(count), 64'd3);
        check("midrst state before", 64'(state_dbg), 64'd2);
        #1 reset = 0;
        #1;
        check("midrst reqcyc", 64'(mem_reqcyc), 64'd0);
        check("midrst count", 64'(count), 64'd0);
        check("midrst empty", 64'(empty), 64'd1);
        @(negedge clk);
        reset = 1;
        tick();
        enq(64'hB00, 64'hBB, 8'h30, 1'b0);
        tick();
        idle_inputs();
        tick();
        check("postrst reqcyc", 64'(mem_reqcyc), 64'd1);
        check("postrst req", mem_req, 64'hB00);
        check("postrst reqdata", mem_reqdata, 64'hBB);
        mem_reqack = 1; mem_writeack = 1;
        tick();
        idle_inputs();
        check("postrst write_done", 64'(write_done), 64'd1);
        check("postrst count", 64'(count), 64'd0);
        tick();

        // ---------------- enqueue on the pop edge ----------------
        enq(64'hC00, 64'hC0, 8'h40, 1'b0); tick();
        enq(64'hC10, 64'hC1, 8'h41, 1'b0); tick();
        idle_inputs();
        check("conc first req", mem_req, 64'hC00);
        mem_reqack = 1;
        tick();
        mem_reqack = 0;
        mem_writeack = 1;
        enq(64'hC20, 64'hC2, 8'h42, 1'b0);
        tick();
        idle_inputs();
        check("conc count", 64'(count), 64'd2);
        check("conc write_done", 64'(write_done), 64'd1);
        tick();
        check("conc next reqcyc", 64'(mem_reqcyc), 64'd1);
        check("conc next req", mem_req, 64'hC10);
        check("conc next reqdata", mem_reqdata, 64'hC1);
        mem_reqack = 1; mem_writeack = 1;
        tick();
        check("conc pop2 count", 64'(count), 64'd1);
        tick();
        check("conc third req", mem_req, 64'hC20);
        tick();
        idle_inputs();
        check("conc final count", 64'(count), 64'd0);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
